dft_bfly_sched: RTL and testbench
=================================

DFT_BFLY_SCHED -- requirements
Module: dft_bfly_sched

Interface
REQ-001 SHALL have parameter LOG2N, default 3, meaning log2 of transform size N (N = 2^LOG2N, legal 1..10).
REQ-002 SHALL have parameter BFLY_LAT, default 2, meaning cycles from butterfly issue to write-back (legal 1..8).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port i_hold  input  1  pauses butterfly issue while high.
REQ-007 SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse at transform completion.
REQ-009 SHALL have port o_stage  output  LOG2N  current stage index s.
REQ-010 SHALL have port o_bfly_valid  output  1  issue strobe for read addresses.
REQ-011 SHALL have port o_rd_addr_a  output  LOG2N  upper-leg sample address.
REQ-012 SHALL have port o_rd_addr_b  output  LOG2N  lower-leg sample address.
REQ-013 SHALL have port o_tw_addr  output  LOG2N-1 (min 1)  twiddle ROM index.
REQ-014 SHALL have port o_wr_en  output  1  write-back strobe.
REQ-015 SHALL have ports o_wr_addr_a, o_wr_addr_b  output  LOG2N  write-back addresses (in-place).

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> (RUN | DONE) -> IDLE.
REQ-017 IDLE: i_start=1 SHALL load stage 0, butterfly counter k=0, go RUN next cycle; i_start ignored in all other states.
REQ-018 RUN: each cycle with i_hold=0 SHALL assert o_bfly_valid and increment k; i_hold=1 SHALL deassert o_bfly_valid and freeze k.
REQ-019 Addresses (combinational from s,k): j = k mod 2^s; o_rd_addr_a = ((k>>s)<<(s+1)) | j; o_rd_addr_b = o_rd_addr_a + 2^s; o_tw_addr = j<<(LOG2N-1-s).
REQ-020 Issuing k = N/2-1 SHALL transition RUN -> DRAIN.
REQ-021 A BFLY_LAT-deep shift line SHALL carry {valid, addr_a, addr_b}; o_wr_en/o_wr_addr_* SHALL equal the entry issued exactly BFLY_LAT cycles earlier, independent of i_hold.
REQ-022 DRAIN SHALL persist until the write of the stage's last butterfly; next cycle: s<LOG2N-1 -> s+1, k=0, RUN; else DONE.
REQ-023 No read of stage s+1 SHALL issue before the final write of stage s (RAW safety).
REQ-024 DONE SHALL last one cycle with o_done=1, then IDLE.
REQ-025 With i_hold=0 throughout, each stage SHALL take N/2+BFLY_LAT cycles; o_done asserts LOG2N*(N/2+BFLY_LAT)+1 cycles after the i_start sample edge.
REQ-026 i_hold during DRAIN SHALL have no effect.
REQ-027 Address arithmetic SHALL be unsigned, LOG2N bits, no wrap beyond N-1.

Reset
REQ-028 i_rst_n=0 SHALL asynchronously force IDLE, s=0, k=0, clear shift line; all outputs 0.
REQ-029 Reset mid-transform SHALL abort with no further o_wr_en and no o_done; next i_start restarts at stage 0.

Configuration
REQ-030 Macro DFT_BFLY_SCHED_PERF_EN defined: SHALL add output o_cycles (16 bits) counting RUN+DRAIN cycles of the last transform, cleared on i_start acceptance, held after DONE, saturating at 16'hFFFF, 0 on reset.
REQ-031 Macro undefined: o_cycles and its counter SHALL be absent; all other behaviour identical.

Verification (LOG2N=3, BFLY_LAT=2)
REQ-032 Pulse i_start, i_hold=0 -> stage 0 pairs (0,1),(2,3),(4,5),(6,7) tw 0,0,0,0; stage 1 (0,2),(1,3),(4,6),(5,7) tw 0,2,0,2; stage 2 (0,4),(1,5),(2,6),(3,7) tw 0,1,2,3.
REQ-033 Same run -> each o_wr_en exactly 2 cycles after matching o_bfly_valid, same addresses; o_done at cycle 19 after start edge; 12 writes total.
REQ-034 i_hold=1 for 3 cycles after first issue of stage 1 -> issue pauses, pending writes still occur, o_done at cycle 22, o_cycles=21 (PERF_EN).
REQ-035 i_start asserted while busy -> ignored, sequence unchanged, single o_done.
REQ-036 i_rst_n low in DRAIN of stage 1 -> outputs 0 immediately, no o_done; fresh i_start repeats REQ-032 sequence.

Source files
------------

// File: rtl/dft_bfly_sched.sv
// Radix-2 in-place DFT butterfly address scheduler: per-stage read/twiddle issue and write-back addresses.
// Latency: write-back strobe trails its issue by exactly BFLY_LAT cycles; done is LOG2N*(N/2+BFLY_LAT)+1 after start.
// Backpressure: i_hold stalls issue in RUN only; in-flight writes keep draining. Optional DFT_BFLY_SCHED_PERF_EN adds o_cycles.
module dft_bfly_sched #(
    parameter int LOG2N    = 3,
    parameter int BFLY_LAT = 2,
    localparam int TW_W    = (LOG2N > 1) ? LOG2N - 1 : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_hold,
    output logic             o_busy,
    output logic             o_done,
    output logic [LOG2N-1:0] o_stage,
    output logic             o_bfly_valid,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [TW_W-1:0]  o_tw_addr,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b
`ifdef DFT_BFLY_SCHED_PERF_EN
    ,
    output logic [15:0]      o_cycles
`endif
);

    localparam logic [LOG2N-1:0] A1       = LOG2N'(1);
    localparam logic [LOG2N-1:0] K_LAST   = LOG2N'((1 << (LOG2N - 1)) - 1);
    localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ADDR_MAX = {LOG2N{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } wb_t;

    state_t           state, state_nxt;
    logic [LOG2N-1:0] s, s_nxt, k, k_nxt;
    logic             bfly;
    logic             last_wr;
    logic [LOG2N-1:0] mask, j, addr_a, addr_b;
    wb_t              line [BFLY_LAT];

    always_comb begin
        mask   = (A1 << s) - A1;
        j      = k & mask;
        addr_a = ((k >> s) << (s + A1)) | j;
        addr_b = addr_a + (A1 << s);
    end

    // Each stage's final butterfly is the only one whose lower leg is N-1.
    assign last_wr = line[BFLY_LAT-1].vld && (line[BFLY_LAT-1].b == ADDR_MAX);

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        k_nxt     = k;
        bfly      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    s_nxt     = '0;
                    k_nxt     = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!i_hold) begin
                    bfly = 1'b1;
                    if (k == K_LAST) begin
                        state_nxt = DRAIN;
                    end else begin
                        k_nxt = k + A1;
                    end
                end
            end
            DRAIN: begin
                if (last_wr) begin
                    if (s == S_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        s_nxt     = s + A1;
                        k_nxt     = '0;
                        state_nxt = RUN;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            k     <= k_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BFLY_LAT; i++) line[i] <= '0;
        end else begin
            line[0] <= {bfly, o_rd_addr_a, o_rd_addr_b};
            for (int i = 1; i < BFLY_LAT; i++) line[i] <= line[i-1];
        end
    end

    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);
    assign o_stage      = s;
    assign o_bfly_valid = bfly;
    assign o_rd_addr_a  = bfly ? addr_a : '0;
    assign o_rd_addr_b  = bfly ? addr_b : '0;
    assign o_tw_addr    = bfly ? TW_W'(j << (S_LAST - s)) : '0;
    assign o_wr_en      = line[BFLY_LAT-1].vld;
    assign o_wr_addr_a  = line[BFLY_LAT-1].a;
    assign o_wr_addr_b  = line[BFLY_LAT-1].b;

`ifdef DFT_BFLY_SCHED_PERF_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cycles <= '0;
        end else if (state == IDLE && i_start) begin
            o_cycles <= '0;
        end else if ((state == RUN || state == DRAIN) && o_cycles != 16'hFFFF) begin
            o_cycles <= o_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dft_bfly_sched.sv
// Directed bench for dft_bfly_sched at LOG2N=3, BFLY_LAT=2: schedule, hold, busy start, mid-run reset.
module tb_dft_bfly_sched;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_hold  = 1'b0;
    logic       o_busy, o_done, o_bfly_valid, o_wr_en;
    logic [2:0] o_stage, o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
    logic [1:0] o_tw_addr;
`ifdef DFT_BFLY_SCHED_PERF_EN
    logic [15:0] o_cycles;
`endif

    dft_bfly_sched #(.LOG2N(3), .BFLY_LAT(2)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_hold       (i_hold),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_stage      (o_stage),
        .o_bfly_valid (o_bfly_valid),
        .o_rd_addr_a  (o_rd_addr_a),
        .o_rd_addr_b  (o_rd_addr_b),
        .o_tw_addr    (o_tw_addr),
        .o_wr_en      (o_wr_en),
        .o_wr_addr_a  (o_wr_addr_a),
        .o_wr_addr_b  (o_wr_addr_b)
`ifdef DFT_BFLY_SCHED_PERF_EN
        ,
        .o_cycles     (o_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-derived schedule for N=8: pairs, twiddles, issue cycles with and without the stage-1 hold.
    int exp_a [12]   = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b [12]   = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_t [12]   = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int exp_s [12]   = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int iss_nh [12]  = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    int iss_h [12]   = '{1, 2, 3, 4, 7, 11, 12, 13, 16, 17, 18, 19};

    int tick = 0;
    int t0   = 0;
    int iss_c[$], iss_a[$], iss_b[$], iss_t[$], iss_s[$];
    int wr_c[$], wr_a[$], wr_b[$], done_c[$];

    always @(negedge i_clk) begin
        tick++;
        if (o_bfly_valid) begin
            iss_c.push_back(tick - t0);
            iss_a.push_back(int'(o_rd_addr_a));
            iss_b.push_back(int'(o_rd_addr_b));
            iss_t.push_back(int'(o_tw_addr));
            iss_s.push_back(int'(o_stage));
        end
        if (o_wr_en) begin
            wr_c.push_back(tick - t0);
            wr_a.push_back(int'(o_wr_addr_a));
            wr_b.push_back(int'(o_wr_addr_b));
        end
        if (o_done) done_c.push_back(tick - t0);
    end

    task automatic clear_log();
        iss_c.delete(); iss_a.delete(); iss_b.delete(); iss_t.delete(); iss_s.delete();
        wr_c.delete();  wr_a.delete();  wr_b.delete();  done_c.delete();
    endtask

    task automatic kick();
        clear_log();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        t0 = tick;
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, " busy"},  32'(o_busy),       0);
        check({nm, " done"},  32'(o_done),       0);
        check({nm, " valid"}, 32'(o_bfly_valid), 0);
        check({nm, " wr_en"}, 32'(o_wr_en),      0);
        check({nm, " stage"}, 32'(o_stage),      0);
        check({nm, " rd_a"},  32'(o_rd_addr_a),  0);
        check({nm, " rd_b"},  32'(o_rd_addr_b),  0);
        check({nm, " tw"},    32'(o_tw_addr),    0);
        check({nm, " wr_a"},  32'(o_wr_addr_a),  0);
        check({nm, " wr_b"},  32'(o_wr_addr_b),  0);
`ifdef DFT_BFLY_SCHED_PERF_EN
        check({nm, " cycles"}, 32'(o_cycles),    0);
`endif
    endtask

    task automatic run_and_check(input string nm, input bit held, input bit poke,
                                 input bit hold_drain, input int exp_done, input int exp_cyc);
        int ec;
        kick();
        for (int c = 1; c <= 30; c++) begin
            i_hold  = (held && c >= 8 && c <= 10) ||
                      (hold_drain && (c == 5 || c == 6 || c == 11 || c == 12));
            i_start = poke && (c == 3 || c == 12 || c == 19);
            @(posedge i_clk); #1;
        end
        i_hold  = 1'b0;
        i_start = 1'b0;
        check({nm, " n_iss"},  iss_c.size(),  12);
        check({nm, " n_wr"},   wr_c.size(),   12);
        check({nm, " n_done"}, done_c.size(), 1);
        if (done_c.size() > 0) check({nm, " done_cyc"}, done_c[0], exp_done);
        for (int i = 0; i < 12; i++) begin
            ec = held ? iss_h[i] : iss_nh[i];
            if (i < iss_c.size()) begin
                check($sformatf("%s iss%0d cyc", nm, i),   iss_c[i], ec);
                check($sformatf("%s iss%0d a", nm, i),     iss_a[i], exp_a[i]);
                check($sformatf("%s iss%0d b", nm, i),     iss_b[i], exp_b[i]);
                check($sformatf("%s iss%0d tw", nm, i),    iss_t[i], exp_t[i]);
                check($sformatf("%s iss%0d stage", nm, i), iss_s[i], exp_s[i]);
            end
            if (i < wr_c.size()) begin
                check($sformatf("%s wr%0d cyc", nm, i), wr_c[i], ec + 2);
                check($sformatf("%s wr%0d a", nm, i),   wr_a[i], exp_a[i]);
                check($sformatf("%s wr%0d b", nm, i),   wr_b[i], exp_b[i]);
            end
        end
        check({nm, " busy_end"}, 32'(o_busy), 0);
`ifdef DFT_BFLY_SCHED_PERF_EN
        check({nm, " cycles"}, 32'(o_cycles), exp_cyc);
`else
        if (exp_cyc < 0) $display("[TB] note: negative cycle expectation");
`endif
    endtask

    initial begin
        #3;
        check_idle_zero("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (2) begin @(posedge i_clk); #1; end

        run_and_check("base",       1'b0, 1'b0, 1'b0, 19, 18);
        run_and_check("hold",       1'b1, 1'b0, 1'b0, 22, 21);
        run_and_check("busy_start", 1'b0, 1'b1, 1'b1, 19, 18);

        // Abort during stage-1 drain (cycle 11 carries the write of issue 9).
        kick();
        repeat (10) begin @(posedge i_clk); #1; end
        check("abort pre busy",  32'(o_busy),  1);
        check("abort pre wr_en", 32'(o_wr_en), 1);
        check("abort pre stage", 32'(o_stage), 1);
        #2 i_rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        clear_log();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (8) begin @(posedge i_clk); #1; end
        check("abort n_wr",   wr_c.size(),   0);
        check("abort n_done", done_c.size(), 0);
        check("abort busy",   32'(o_busy),   0);

        run_and_check("restart", 1'b0, 1'b0, 1'b0, 19, 18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
